// File: rtl/nios2_qsys_pio_pkg.sv
// rtl/nios2_qsys_pio_pkg.sv - register map constants for the PIO output generator
package nios2_qsys_pio_pkg;

  localparam logic [2:0] ADDR_DATA       = 3'd0;
  localparam logic [2:0] ADDR_BLINK_MASK = 3'd1;
  localparam logic [2:0] ADDR_PERIOD     = 3'd2;
  localparam logic [2:0] ADDR_OUTSET     = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR     = 3'd5;
  localparam logic [2:0] ADDR_STATUS     = 3'd6;

  localparam int STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/nios2_qsys_pio_blink_timer.sv
// rtl/nios2_qsys_pio_blink_timer.sv - PERIOD-driven down counter and blink phase flop
module nios2_qsys_pio_blink_timer #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PRESCALE_W-1:0] period,
  input  logic                  period_wr,
  output logic                  phase
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic                  phase_q, phase_d;

  // A PERIOD write restarts the half-period and beats a coincident expiry.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (period_wr) begin
      cnt_d   = period;
      phase_d = 1'b0;
    end else if (period == '0) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == '0) begin
      cnt_d   = period;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q - PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/nios2_qsys_pio_out_gen.sv
// rtl/nios2_qsys_pio_out_gen.sv - Avalon-MM PIO output with set/clear and optional blink (NIOS2_QSYS_PIO_BLINK_EN)
module nios2_qsys_pio_out_gen
  import nios2_qsys_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PRESCALE_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] data_q, data_d;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  always_comb begin
    data_d = data_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:   data_d = wdata;
        ADDR_OUTSET: data_d = data_q | wdata;
        ADDR_OUTCLR: data_d = data_q & ~wdata;
        default:     data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_q <= RESET_VALUE;
    else          data_q <= data_d;
  end

`ifdef NIOS2_QSYS_PIO_BLINK_EN
  logic [WIDTH-1:0]      mask_q, mask_d;
  logic [PRESCALE_W-1:0] period_q, period_d;
  logic                  period_wr;
  logic                  phase;

  assign period_wr = wr_en && (address == ADDR_PERIOD);
  assign period_d  = period_wr ? writedata[PRESCALE_W-1:0] : period_q;
  assign mask_d    = (wr_en && (address == ADDR_BLINK_MASK)) ? wdata : mask_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q   <= '0;
      period_q <= '0;
    end else begin
      mask_q   <= mask_d;
      period_q <= period_d;
    end
  end

  // The timer sees the incoming value so a PERIOD write reloads the counter on the same edge.
  nios2_qsys_pio_blink_timer #(
    .PRESCALE_W(PRESCALE_W)
  ) u_blink_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .period   (period_d),
    .period_wr(period_wr),
    .phase    (phase)
  );

  assign out_port = data_q & ~(mask_q & {WIDTH{phase}});
`else
  assign out_port = data_q;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:       readdata[WIDTH-1:0] = data_q;
`ifdef NIOS2_QSYS_PIO_BLINK_EN
      ADDR_BLINK_MASK: readdata[WIDTH-1:0] = mask_q;
      ADDR_PERIOD:     readdata[PRESCALE_W-1:0] = period_q;
      ADDR_STATUS:     readdata[STATUS_PHASE_BIT] = phase;
`endif
      default:         readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nios2_qsys_pio_out_gen.sv
// tb/tb_nios2_qsys_pio_out_gen.sv - scoreboard bench for nios2_qsys_pio_out_gen
module tb_nios2_qsys_pio_out_gen;
  import nios2_qsys_pio_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  nios2_qsys_pio_out_gen #(
    .WIDTH      (8),
    .RESET_VALUE(8'hA5),
    .PRESCALE_W (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          is_port;
    logic [31:0] exp;
  } exp_t;

  exp_t        exp_q[$];
  logic        mon_req;
  int          n_vec;
  int          n_err;
  exp_t        mon_e;
  logic [31:0] mon_act;

  // Monitor: drains every pending expectation in the sampled cycle.
  always @(negedge clk) begin
    if (mon_req) begin
      while (exp_q.size() > 0) begin
        mon_e   = exp_q.pop_front();
        mon_act = mon_e.is_port ? {24'h0, out_port} : readdata;
        n_vec++;
        if (mon_act !== mon_e.exp) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", mon_e.name, mon_act, mon_e.exp);
        end
      end
    end
  end

  task automatic wr_raw(input logic [2:0] a, input logic [31:0] d, input logic cs, input logic wn);
    address    = a;
    writedata  = d;
    chipselect = cs;
    write_n    = wn;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_raw(a, d, 1'b1, 1'b0);
  endtask

  task automatic chk(input logic [2:0] a, input logic cs, input logic [31:0] exp_rd,
                     input logic [7:0] exp_port, input string nm);
    exp_t e;
    address    = a;
    chipselect = cs;
    write_n    = 1'b1;
    e.name = {nm, "_rd"};   e.is_port = 1'b0; e.exp = exp_rd;
    exp_q.push_back(e);
    e.name = {nm, "_port"}; e.is_port = 1'b1; e.exp = {24'h0, exp_port};
    exp_q.push_back(e);
    mon_req = 1'b1;
    @(posedge clk);
    #1;
    mon_req    = 1'b0;
    chipselect = 1'b0;
  endtask

`ifdef NIOS2_QSYS_PIO_BLINK_EN
  logic [8:0] ph_a;
  logic [7:0] ph_b;
`endif

  initial begin
    n_vec      = 0;
    n_err      = 0;
    mon_req    = 1'b0;
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk(ADDR_DATA, 1'b1, 32'hA5, 8'hA5, "in_reset");
    reset_n = 1'b1;

    for (int a = 0; a < 8; a++)
      chk(3'(a), 1'b1, (a == 0) ? 32'hA5 : 32'h0, 8'hA5, "reset_map");

    wr(ADDR_DATA, 32'h0F);
    wr(ADDR_OUTSET, 32'hF0);
    wr(ADDR_OUTCLR, 32'h81);
    chk(ADDR_DATA, 1'b1, 32'h7E, 8'h7E, "set_clr");
    chk(ADDR_OUTSET, 1'b1, 32'h0, 8'h7E, "outset_rd");
    chk(ADDR_OUTCLR, 1'b1, 32'h0, 8'h7E, "outclr_rd");
    chk(ADDR_DATA, 1'b0, 32'h7E, 8'h7E, "rd_no_cs");

    wr_raw(ADDR_DATA, 32'h55, 1'b0, 1'b0);
    chk(ADDR_DATA, 1'b1, 32'h7E, 8'h7E, "wr_no_cs");
    wr_raw(ADDR_DATA, 32'h55, 1'b1, 1'b1);
    chk(ADDR_DATA, 1'b1, 32'h7E, 8'h7E, "wr_n_high");

    wr(ADDR_DATA, 32'hFFFF_FF3C);
    chk(ADDR_DATA, 1'b1, 32'h3C, 8'h3C, "upper_bits");
    wr(3'd3, 32'h12);
    wr(3'd7, 32'h34);
    chk(3'd3, 1'b1, 32'h0, 8'h3C, "rsvd3");
    chk(3'd7, 1'b1, 32'h0, 8'h3C, "rsvd7");
    chk(ADDR_DATA, 1'b1, 32'h3C, 8'h3C, "rsvd_no_effect");

`ifdef NIOS2_QSYS_PIO_BLINK_EN
    wr(ADDR_DATA, 32'hFF);
    wr(ADDR_BLINK_MASK, 32'h01);
    wr(ADDR_PERIOD, 32'd3);
    ph_a = 9'b1_0000_1111 ^ 9'b1_1111_1111;
    for (int k = 0; k < 9; k++)
      chk(ADDR_STATUS, 1'b1, {31'h0, ph_a[k]}, ph_a[k] ? 8'hFE : 8'hFF, "blink_p3");
    repeat (2) @(posedge clk);
    #1;
    wr(ADDR_PERIOD, 32'd5);
    ph_b = 8'b1100_0000;
    for (int k = 0; k < 8; k++)
      chk(ADDR_STATUS, 1'b1, {31'h0, ph_b[k]}, ph_b[k] ? 8'hFE : 8'hFF, "period_at_expiry");
    chk(ADDR_PERIOD, 1'b1, 32'd5, 8'hFE, "period_rd");
    chk(ADDR_BLINK_MASK, 1'b1, 32'h01, 8'hFE, "mask_rd");
`else
    wr(ADDR_PERIOD, 32'd3);
    wr(ADDR_BLINK_MASK, 32'hFF);
    for (int k = 0; k < 6; k++) begin
      chk(ADDR_PERIOD, 1'b1, 32'h0, 8'h3C, "noblink_period");
      chk(ADDR_BLINK_MASK, 1'b1, 32'h0, 8'h3C, "noblink_mask");
      chk(ADDR_STATUS, 1'b1, 32'h0, 8'h3C, "noblink_status");
    end
`endif

    reset_n = 1'b0;
    chk(ADDR_DATA, 1'b1, 32'hA5, 8'hA5, "rst_async");
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk(ADDR_PERIOD, 1'b1, 32'h0, 8'hA5, "post_rst_period");
      chk(ADDR_BLINK_MASK, 1'b1, 32'h0, 8'hA5, "post_rst_mask");
      chk(ADDR_STATUS, 1'b1, 32'h0, 8'hA5, "post_rst_status");
    end
    chk(ADDR_DATA, 1'b1, 32'hA5, 8'hA5, "post_rst_data");

    repeat (2) @(posedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
